dma_instr_queue: RTL
====================

Name: dma_instr_queue

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO of DMA instructions.
- Sits directly upstream of dma_uart and replaces fake_queue. It is a drop-in on the existing dma_instr / empty / re interface.
- The write side is filled by the instruction loader.
- The top level pops one instruction per unfrozen cycle and decodes bit 21 (valid) and bit 20 (1 = write, 0 = read).

Parameters:
- DEPTH, 16, number of entries. Must be a power of 2 and ≥ 2.
- WIDTH, 22, instruction width. Bit WIDTH-1 is valid; bit WIDTH-2 is the read/write select.
- AFULL_LVL, 12, count at or above which almost_full asserts.

Ports:
- clk  in  1  system clock; all logic is on posedge.
- reset  in  1  synchronous, active-low reset. reset==0 at a posedge clears the queue.
- instr_w  in  WIDTH  instruction to enqueue.
- we  in  1  enqueue strobe.
- full  out  1  queue holds DEPTH entries.
- almost_full  out  1  count ≥ AFULL_LVL.
- dma_instr  out  WIDTH  head-of-queue instruction (FWFT).
- re  in  1  pop strobe.
- empty  out  1  queue holds 0 entries.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH x WIDTH register array, rd_ptr and wr_ptr of $clog2(DEPTH) bits, count of $clog2(DEPTH)+1 bits.
- Pointers wrap naturally modulo DEPTH.
- Reset (reset==0 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - Outputs: empty=1, full=0, almost_full=0, dma_instr=0.
  - Array contents need not be cleared.
  - Reset overrides we/re in the same cycle.
  - A reset mid-stream discards all entries.
- Flags are combinational from count:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_full = (count≥AFULL_LVL)
- Head output:
  - dma_instr = mem[rd_ptr] when !empty, else all-zero.
  - When empty, bit 21 is therefore 0 and downstream sees no instruction.
- Push accepted when: we==1, instr_w[WIDTH-1]==1, and (!full or pop accepted this cycle).
  - Writes with the valid bit clear are discarded silently and never stored.
- Pop accepted when re==1 and !empty.
  - re while empty is ignored; rd_ptr is unchanged.
  - re is allowed to be held high continuously, including during reset.
- Latency:
  - A push at edge N makes the entry visible on dma_instr and drops empty after edge N (zero bubble, visible in cycle N+1).
  - A pop at edge N presents the next entry in cycle N+1.
- Simultaneous accepted push and pop:
  - count is unchanged and both pointers advance.
  - When full: the write is accepted because a slot frees this edge.
  - When empty: the pop is rejected (nothing to pop), so only the push takes effect and count goes 0→1.
- Push when full with no pop: dropped; state is unchanged.
- count never exceeds DEPTH and never underflows.
- Ordering is strict FIFO. No reordering and no bypass of stored entries.

Optional Feature:
- Macro: DMA_INSTR_QUEUE_ERR_EN.
- When defined, two extra output ports are added:
  - ovf (1 bit): sticky; set when we==1 with the valid bit set is dropped because the queue is full with no pop.
  - udf (1 bit): sticky; set when re==1 while empty, except while reset==0.
  - Both clear only on reset==0.
  - Both reset to 0.
- When undefined:
  - The ports and logic are absent.
  - Drops and empty pops are silent.
  - All other behaviour is identical.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then release with we=0, re=1 → empty=1, count=0, dma_instr=22'h0 every cycle, no pointer movement. With _ERR_EN, udf stays 0 during reset and is set the first cycle after release.
- Single push/pop: push 22'h300078 at edge N → at N+1 dma_instr=22'h300078, empty=0, count=1. Assert re at edge N+1 → at N+2 empty=1, dma_instr=0.
- Fill and overflow (DEPTH=16): push values 22'h200000+i for i=0..16 with re=0 → almost_full rises after the 12th push, full=1 after the 16th push, 17th push dropped, count=16. Pop 16 times → values read out in order 0..15. With _ERR_EN, ovf=1.
- Full simultaneous push/pop: queue full, we=1 with 22'h3000AA and re=1 in the same cycle → count stays 16, head advances, 22'h3000AA emerges as the 16th pop afterwards.
- Invalid-bit filter and empty simultaneity: push 22'h100005 (bit 21=0) → count stays 0. Then push 22'h200007 with re=1 while empty → count=1, dma_instr=22'h200007.
- Wrap and reset mid-stream: run 40 interleaved push/pop cycles crossing pointer wrap and compare against a scoreboard. Then assert reset=0 with count=5 → next cycle count=0, empty=1, dma_instr=0.

Source files
------------

// File: rtl/dma_instr_queue.sv
// First-word-fall-through DMA instruction queue feeding dma_uart.
// Define DMA_INSTR_QUEUE_ERR_EN to add the sticky ovf/udf error outputs.
module dma_instr_queue #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 22,
  parameter int AFULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         instr_w,
  input  logic                     we,
  output logic                     full,
  output logic                     almost_full,
  output logic [WIDTH-1:0]         dma_instr,
  input  logic                     re,
  output logic                     empty,
`ifdef DMA_INSTR_QUEUE_ERR_EN
  output logic                     ovf,
  output logic                     udf,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = re && !w_empty;
  // A full queue still accepts a write when a pop frees a slot on the same edge.
  assign w_push  = we && instr_w[WIDTH-1] && (!w_full || w_pop);

  assign empty       = w_empty;
  assign full        = w_full;
  assign almost_full = (r_count >= AFULL_CNT);
  assign count       = r_count;
  assign dma_instr   = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= instr_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef DMA_INSTR_QUEUE_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (we && instr_w[WIDTH-1] && w_full && !w_pop) begin
        ovf <= 1'b1;
      end
      if (re && w_empty) begin
        udf <= 1'b1;
      end
    end
  end
`endif

endmodule
